// File: rtl/sram_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_axil_pkg
//  Description : Shared types and constants for the AXI4-Lite SRAM slave:
//                FSM state encoding, response codes, LFSR seed and taps.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_axil_pkg;

    // Slave FSM states. Explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_WAIT = 3'd1,
        R_RESP = 3'd2,
        W_DATA = 3'd3,
        W_WAIT = 3'd4,
        B_RESP = 3'd5
    } state_t;

    // Response codes carried on rresp/bresp.
    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_DECERR = 1'b1;

    // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    // Feedback is the XOR of state bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage : sram_axil_pkg
`default_nettype wire

// File: rtl/sram_axil_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_axil_if
//  Description : AXI4-Lite-style bus bundle between the load/store unit
//                (master) and the SRAM slave.
//  Ports       : none (pure signal bundle); modports master / slave.
//                AR: araddr, arvalid, arready
//                R : rdata, rresp, rvalid, rready
//                AW: awaddr, awvalid, awready
//                W : wdata, wstrb (per-bit mask), wvalid, wready
//                B : bresp, bvalid, bready
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_axil_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [31:0] wstrb;
    logic        wvalid;
    logic        wready;

    logic        bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, input  arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input  awready,
        output wdata, wstrb, wvalid, input  wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input  rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input  bready
    );

endinterface : sram_axil_if
`default_nettype wire

// File: rtl/sram_axil_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr8
//  Description : Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1),
//                shifting left with feedback into bit 0. Seeded non-zero on
//                reset, so the all-zero lock-up state is never entered.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                dout - current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
    import sram_axil_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    output logic [7:0]      dout
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dout = lfsr_q;

endmodule : lfsr8
`default_nettype wire

// File: rtl/sram_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : sram_axil_slave
//  Description : Single-port SRAM behind an AXI4-Lite-style slave. One
//                outstanding read or write at a time; each response is
//                delayed by a wait-state count taken from an internal LFSR.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous reset, active low
//                bus      - sram_axil_if.slave (AR/R/AW/W/B channels)
//                lfsr_out - current LFSR state, exported for master jitter
//  Config      : SRAM_RAND_DELAY_EN - when defined, wait states come from
//                lfsr_out[DELAY_BITS-1:0]; otherwise latency is fixed at 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_axil_slave
    import sram_axil_pkg::*;
#(
    parameter int MEM_WORDS  = 4096,
    parameter int DELAY_BITS = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sram_axil_if.slave  bus,
    output logic [7:0]  lfsr_out
);

    localparam int         IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 state_q,  state_d;
    logic [DELAY_BITS-1:0]  cnt_q,    cnt_d;
    logic [31:0]            addr_q,   addr_d;
    logic [31:0]            rdata_q,  rdata_d;
    logic                   rresp_q,  rresp_d;
    logic                   bresp_q,  bresp_d;
    // Holds the ready outputs low through the first edge after reset release.
    logic                   live_q;

    logic [31:0]            mem [MEM_WORDS];

    // ------------------------------------------------------------------------
    // LFSR and wait-state source
    // ------------------------------------------------------------------------
    logic [7:0]             lfsr_q;
    logic [DELAY_BITS-1:0]  delay;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .dout (lfsr_q)
    );

    assign lfsr_out = lfsr_q;

`ifdef SRAM_RAND_DELAY_EN
    assign delay = lfsr_q[DELAY_BITS-1:0];
`else
    assign delay = '0;
`endif

    // ------------------------------------------------------------------------
    // Address decode and datapath on the latched address
    // ------------------------------------------------------------------------
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic [4:0]       shamt;
    logic [31:0]      word_rd;
    logic [31:0]      word_wr;
    logic             mem_we;

    assign in_range = ({1'b0, addr_q} < ADDR_LIMIT);
    assign word_idx = addr_q[IDX_W+1:2];
    assign shamt    = {addr_q[1:0], 3'b000};
    assign word_rd  = mem[word_idx];

    // Strobe and data are both LSB-aligned and shifted into byte lane
    // position; bits pushed past bit 31 are discarded.
    assign word_wr  = (word_rd & ~(bus.wstrb << shamt))
                    | ((bus.wdata & bus.wstrb) << shamt);

    // ------------------------------------------------------------------------
    // FSM next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        bresp_d = bresp_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                // Read has priority when both address channels are valid.
                if (live_q && bus.arvalid) begin
                    addr_d  = bus.araddr;
                    cnt_d   = delay;
                    state_d = R_WAIT;
                end else if (live_q && bus.awvalid) begin
                    addr_d  = bus.awaddr;
                    state_d = W_DATA;
                end
            end

            R_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = in_range ? (word_rd >> shamt) : 32'h0;
                    rresp_d = in_range ? RESP_OKAY : RESP_DECERR;
                    state_d = R_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            R_RESP: begin
                if (bus.rready) begin
                    state_d = IDLE;
                end
            end

            W_DATA: begin
                if (bus.wvalid) begin
                    mem_we  = in_range;
                    bresp_d = in_range ? RESP_OKAY : RESP_DECERR;
                    cnt_d   = delay;
                    state_d = W_WAIT;
                end
            end

            W_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = B_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            B_RESP: begin
                if (bus.bready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            bresp_q <= RESP_OKAY;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            bresp_q <= bresp_d;
            live_q  <= 1'b1;
        end
    end

    // Memory array has no reset so it maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= word_wr;
        end
    end

    // ------------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------------
    assign bus.arready = live_q && (state_q == IDLE);
    assign bus.awready = live_q && (state_q == IDLE);
    assign bus.wready  = (state_q == W_DATA);
    assign bus.rvalid  = (state_q == R_RESP);
    assign bus.bvalid  = (state_q == B_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.bresp   = bresp_q;

endmodule : sram_axil_slave
`default_nettype wire

// File: tb/tb_sram_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_axil_slave
//  Description : Self-checking bench for sram_axil_slave. Directed scenarios
//                plus a randomized mix, all checked against a word-array
//                memory model and an independent LFSR model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_axil_slave;

    localparam int          MEM_WORDS = 4096;
    localparam logic [31:0] LIMIT     = 32'h0000_4000;
    localparam int          BOUND     = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lfsr_out;

    int checks   = 0;
    int failures = 0;

    sram_axil_if bus ();

    sram_axil_slave #(
        .MEM_WORDS  (MEM_WORDS),
        .DELAY_BITS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .bus      (bus),
        .lfsr_out (lfsr_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference models ----------------
    logic [7:0]  lfsr_m;
    logic [31:0] ref_mem [int];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 8'h01;
        else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    function automatic int exp_delay();
`ifdef SRAM_RAND_DELAY_EN
        return int'(lfsr_m[3:0]);
`else
        return 0;
`endif
    endfunction

    // Bit-by-bit merge: destination bit i takes data bit (i - 8*off) when
    // the strobe bit at that source position is set.
    function automatic logic [31:0] model_merge(logic [31:0] old, logic [31:0] data,
                                                logic [31:0] strb, int off);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 32; i++) begin
            int src;
            src = i - 8 * off;
            if (src >= 0 && strb[src]) w[i] = data[src];
        end
        return w;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] addr);
        logic [31:0] w;
        if (addr >= LIMIT) return 32'h0;
        w = ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0;
        return w >> (8 * int'(addr[1:0]));
    endfunction

    // ---------------- bus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.arready && n < BOUND) begin step(); n++; end
        if (!bus.arready) begin
            checks++; failures++;
            $display("FAIL %s: arready timeout after %0d cycles", name, n);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic resp, output int lat, output int dexp);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        wait_ready("rd_ar");
        dexp = exp_delay();
        step();
        bus.arvalid = 1'b0;
        lat = 0;
        while (!bus.rvalid && lat < BOUND) begin step(); lat++; end
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] strb, output logic resp,
                            output int lat, output int dexp);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        wait_ready("wr_aw");
        step();
        bus.awvalid = 1'b0;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        dexp = exp_delay();
        step();
        bus.wvalid = 1'b0;
        if (addr < LIMIT)
            ref_mem[int'(addr >> 2)] = model_merge(
                ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0,
                data, strb, int'(addr[1:0]));
        lat = 0;
        while (!bus.bvalid && lat < BOUND) begin step(); lat++; end
        resp = bus.bresp;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] seq [6];
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0 ||
            bus.rdata !== 32'h0 || bus.rresp !== 1'b0 || bus.bresp !== 1'b0 ||
            lfsr_out !== 8'h01) begin
            failures++;
            $display("FAIL reset_outputs: rdy/vld=%b rdata=%h lfsr=%h, required 00000 0 01",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid},
                     bus.rdata, lfsr_out);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lfsr_out !== seq[k]) begin
                failures++;
                $display("FAIL lfsr_seq[%0d]: got %h required %h", k, lfsr_out, seq[k]);
            end
            if (k == 1) begin
                checks++;
                if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b11000) begin
                    failures++;
                    $display("FAIL ready_after_reset: got %b required 11000",
                             {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
                end
            end
            if (k < 5) step();
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] d; logic r; int lat, dx;
        do_write(32'h100, 32'hDEADBEEF, 32'hFFFF_FFFF, r, lat, dx);
        checks++;
        if (r !== 1'b0 || lat != 1 + dx) begin
            failures++;
            $display("FAIL word_write: bresp=%b lat=%0d required 0 lat=%0d", r, lat, 1 + dx);
        end
        do_read(32'h100, d, r, lat, dx);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 1'b0 || lat != 1 + dx) begin
            failures++;
            $display("FAIL word_read: rdata=%h rresp=%b lat=%0d required DEADBEEF 0 lat=%0d",
                     d, r, lat, 1 + dx);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] d; logic r; int lat, dx;
        do_write(32'h101, 32'h55, 32'hFF, r, lat, dx);
        do_read(32'h100, d, r, lat, dx);
        checks++;
        if (d !== 32'hDEAD55EF || r !== 1'b0) begin
            failures++;
            $display("FAIL byte_write: rdata=%h rresp=%b required DEAD55EF 0", d, r);
        end
        do_read(32'h102, d, r, lat, dx);
        checks++;
        if (d !== 32'h0000DEAD) begin
            failures++;
            $display("FAIL unaligned_read: rdata=%h required 0000DEAD", d);
        end
    endtask

    task automatic test_decode_error();
        logic [31:0] d; logic r; int lat, dx;
        do_write(32'h0, 32'h12345678, 32'hFFFF_FFFF, r, lat, dx);
        do_read(LIMIT, d, r, lat, dx);
        checks++;
        if (r !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL decerr_read: rresp=%b rdata=%h required 1 00000000", r, d);
        end
        do_write(LIMIT, 32'hCAFEF00D, 32'hFFFF_FFFF, r, lat, dx);
        checks++;
        if (r !== 1'b1) begin
            failures++;
            $display("FAIL decerr_write: bresp=%b required 1", r);
        end
        do_read(32'h0, d, r, lat, dx);
        checks++;
        if (d !== 32'h12345678 || r !== 1'b0) begin
            failures++;
            $display("FAIL decerr_no_alias: rdata=%h rresp=%b required 12345678 0", d, r);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.araddr  = 32'h100;
        bus.arvalid = 1'b1;
        wait_ready("bp_ar");
        step();
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < BOUND) begin step(); n++; end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEAD55EF || bus.arready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure[%0d]: rvalid=%b rdata=%h arready=%b required 1 DEAD55EF 0",
                         k, bus.rvalid, bus.rdata, bus.arready);
            end
            step();
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] d; logic r; int n, lat, dx;
        bus.araddr  = 32'h100;
        bus.arvalid = 1'b1;
        bus.awaddr  = 32'h104;
        bus.awvalid = 1'b1;
        wait_ready("sim_ar");
        step();
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < BOUND) begin
            checks++;
            if (bus.awready !== 1'b0) begin
                failures++;
                $display("FAIL sim_awready_wait: awready=%b required 0", bus.awready);
            end
            step(); n++;
        end
        checks++;
        if (bus.rdata !== 32'hDEAD55EF || bus.awready !== 1'b0) begin
            failures++;
            $display("FAIL sim_read_first: rdata=%h awready=%b required DEAD55EF 0",
                     bus.rdata, bus.awready);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        checks++;
        if (bus.awready !== 1'b1) begin
            failures++;
            $display("FAIL sim_awready_after: awready=%b required 1", bus.awready);
        end
        step();
        bus.awvalid = 1'b0;
        checks++;
        if (bus.wready !== 1'b1) begin
            failures++;
            $display("FAIL sim_wready: wready=%b required 1", bus.wready);
        end
        bus.wdata  = 32'hA5A5_0F0F;
        bus.wstrb  = 32'hFFFF_FFFF;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        ref_mem[int'(32'h104 >> 2)] = 32'hA5A5_0F0F;
        n = 0;
        while (!bus.bvalid && n < BOUND) begin step(); n++; end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        do_read(32'h104, d, r, lat, dx);
        checks++;
        if (d !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL sim_write_data: rdata=%h required A5A50F0F", d);
        end
    endtask

    task automatic test_latency();
        logic [31:0] d; logic r; int lat, dx;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lfsr_out !== lfsr_m) begin
                failures++;
                $display("FAIL lfsr_track[%0d]: got %h required %h", k, lfsr_out, lfsr_m);
            end
            if (k[0]) begin
                do_write(32'h108, $urandom, 32'hFFFF_FFFF, r, lat, dx);
            end else begin
                do_read(32'h100, d, r, lat, dx);
            end
            checks++;
            if (lat != 1 + dx) begin
                failures++;
                $display("FAIL latency[%0d]: got %0d required %0d", k, lat, 1 + dx);
            end
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic r; int lat, dx;
        bus.awaddr  = 32'h100;
        bus.awvalid = 1'b1;
        wait_ready("abort_aw");
        step();
        bus.awvalid = 1'b0;
        bus.wdata   = 32'h0BAD_0BAD;
        bus.wstrb   = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.wready !== 1'b0 || lfsr_out !== 8'h01) begin
            failures++;
            $display("FAIL abort_reset: wready=%b lfsr=%h required 0 01", bus.wready, lfsr_out);
        end
        step();
        rst_n = 1'b1;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        do_read(32'h100, d, r, lat, dx);
        checks++;
        if (d !== model_read(32'h100)) begin
            failures++;
            $display("FAIL abort_dropped: rdata=%h required %h", d, model_read(32'h100));
        end
    endtask

    task automatic test_random();
        logic [31:0] d, a, wd, st; logic r; int lat, dx;
        logic [31:0] strbs [3];
        strbs = '{32'hFF, 32'hFFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 16; i++)
            do_write(32'h200 + 32'(4 * i), $urandom, 32'hFFFF_FFFF, r, lat, dx);
        for (int k = 0; k < 40; k++) begin
            a  = ($urandom_range(0, 7) == 0) ? LIMIT + 32'($urandom_range(0, 4095))
                                             : 32'h200 + 32'($urandom_range(0, 63));
            wd = $urandom;
            st = strbs[$urandom_range(0, 2)];
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, wd, st, r, lat, dx);
                checks++;
                if (r !== (a >= LIMIT) || lat != 1 + dx) begin
                    failures++;
                    $display("FAIL rand_write[%0d] @%h: bresp=%b lat=%0d required %b lat=%0d",
                             k, a, r, lat, a >= LIMIT, 1 + dx);
                end
            end else begin
                do_read(a, d, r, lat, dx);
                checks++;
                if (d !== model_read(a) || r !== (a >= LIMIT) || lat != 1 + dx) begin
                    failures++;
                    $display("FAIL rand_read[%0d] @%h: rdata=%h rresp=%b lat=%0d required %h %b lat=%0d",
                             k, a, d, r, lat, model_read(a), a >= LIMIT, 1 + dx);
                end
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb   = '0;   bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_write();
        test_decode_error();
        test_backpressure();
        test_simultaneous();
        test_latency();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_sram_axil_slave
`default_nettype wire
